regfile_mp: RTL and testbench

- Parametrised multi-port register file; next generation of the single-port CPU register file.
- Sits in the decode stage. Provides two registered read ports and two write-back ports (ALU, load).
- Includes write-to-read bypass, an optional hardwired zero register, and a per-register pending-write scoreboard for hazard detection.
- All state updates on the rising edge only; no negedge writes.

---
 rtl/regfile_mp.sv | 115 +++++++++++
 tb/tb_regfile_mp.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with write-to-read bypass and pending-write scoreboard
//
// Ports:
//   clock, reset_n                 clock and synchronous active-low reset
//   rd_en, rd_addr_a, rd_addr_b    read request (addresses captured when rd_en = 1)
//   rd_data_a, rd_data_b           registered read data
//   rd_busy_a, rd_busy_b           registered scoreboard bits for the read addresses
//   rd_valid                       high the cycle after a capture
//   wr0_en, wr0_addr, wr0_data     write port 0 (ALU write-back)
//   wr1_en, wr1_addr, wr1_data     write port 1 (load write-back), wins over wr0
//   busy_set_en, busy_set_addr     mark a destination register pending
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_busy_a,
    output logic              rd_busy_b,
    output logic              rd_valid,
    input  logic              wr0_en,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    input  logic              wr1_en,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    input  logic              busy_set_en,
    input  logic [ADDR_W-1:0] busy_set_addr
);

    localparam int NUM_REGS = 2**ADDR_W;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [NUM_REGS-1:0] busy_src;
    logic                zero_wr0;
    logic                zero_wr1;
    logic                zero_set;
    logic                zero_a;
    logic                zero_b;
    logic                wr0_ok;
    logic                wr1_ok;
    logic                set_ok;
    logic [DATA_W-1:0]   val_a;
    logic [DATA_W-1:0]   val_b;

    // Address-0 hits only matter when register 0 is hardwired.
    assign zero_wr0 = (ZERO_REG != 0) && (wr0_addr == '0);
    assign zero_wr1 = (ZERO_REG != 0) && (wr1_addr == '0);
    assign zero_set = (ZERO_REG != 0) && (busy_set_addr == '0);
    assign zero_a   = (ZERO_REG != 0) && (rd_addr_a == '0);
    assign zero_b   = (ZERO_REG != 0) && (rd_addr_b == '0);

    assign wr0_ok = wr0_en && !zero_wr0;
    assign wr1_ok = wr1_en && !zero_wr1;
    assign set_ok = busy_set_en && !zero_set;

    // Writes clear first, then issue sets: a new producer supersedes the retiring one.
    always_comb begin
        busy_nxt = busy;
        if (wr0_ok) busy_nxt[wr0_addr] = 1'b0;
        if (wr1_ok) busy_nxt[wr1_addr] = 1'b0;
        if (set_ok) busy_nxt[busy_set_addr] = 1'b1;
    end

    assign busy_src = (BYPASS != 0) ? busy_nxt : busy;

    // Forwarding order mirrors the write order, so wr1 overrides wr0.
    always_comb begin
        val_a = regs[rd_addr_a];
        val_b = regs[rd_addr_b];
        if (BYPASS != 0) begin
            if (wr0_ok && (wr0_addr == rd_addr_a)) val_a = wr0_data;
            if (wr1_ok && (wr1_addr == rd_addr_a)) val_a = wr1_data;
            if (wr0_ok && (wr0_addr == rd_addr_b)) val_b = wr0_data;
            if (wr1_ok && (wr1_addr == rd_addr_b)) val_b = wr1_data;
        end
        if (zero_a) val_a = '0;
        if (zero_b) val_b = '0;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            busy      <= '0;
            rd_data_a <= '0;
            rd_data_b <= '0;
            rd_busy_a <= 1'b0;
            rd_busy_b <= 1'b0;
            rd_valid  <= 1'b0;
        end else begin
            if (wr0_ok) regs[wr0_addr] <= wr0_data;
            if (wr1_ok) regs[wr1_addr] <= wr1_data;
            busy     <= busy_nxt;
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data_a <= val_a;
                rd_data_b <= val_b;
                rd_busy_a <= busy_src[rd_addr_a];
                rd_busy_b <= busy_src[rd_addr_b];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp in two configurations
module tb_regfile_mp;

    typedef struct {
        logic        rst_n;
        logic        rd_en;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        w0e;
        logic [4:0]  w0a;
        logic [63:0] w0d;
        logic        w1e;
        logic [4:0]  w1a;
        logic [63:0] w1d;
        logic        bse;
        logic [4:0]  bsa;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic [31:0] e0a;
        logic        e0b;
        logic [63:0] e1a;
        logic        e1b;
        logic        ev;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset_n, rd_en, wr0_en, wr1_en, busy_set_en;
    logic [4:0]  rd_addr_a, rd_addr_b, wr0_addr, wr1_addr, busy_set_addr;
    logic [63:0] wr0_data, wr1_data;

    logic [31:0] o0_ra, o0_rb;
    logic        o0_ba, o0_bb, o0_v;
    logic [63:0] o1_ra, o1_rb;
    logic        o1_ba, o1_bb, o1_v;

    int errors = 0;
    int checks = 0;

    // Reference state: cfg 0 = 32/5 zero-reg bypass, cfg 1 = 64/4 plain no-bypass.
    logic [63:0] m_reg [2][32];
    bit          m_busy [2][32];
    logic [63:0] m_ra [2];
    logic [63:0] m_rb [2];
    bit          m_ba [2];
    bit          m_bb [2];
    bit          m_v [2];

    always #5 clock = ~clock;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut0 (
        .clock(clock), .reset_n(reset_n), .rd_en(rd_en),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(o0_ra), .rd_data_b(o0_rb),
        .rd_busy_a(o0_ba), .rd_busy_b(o0_bb), .rd_valid(o0_v),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data[31:0]),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data[31:0]),
        .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr)
    );

    regfile_mp #(.DATA_W(64), .ADDR_W(4), .ZERO_REG(0), .BYPASS(0)) dut1 (
        .clock(clock), .reset_n(reset_n), .rd_en(rd_en),
        .rd_addr_a(rd_addr_a[3:0]), .rd_addr_b(rd_addr_b[3:0]),
        .rd_data_a(o1_ra), .rd_data_b(o1_rb),
        .rd_busy_a(o1_ba), .rd_busy_b(o1_bb), .rd_valid(o1_v),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr[3:0]), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr[3:0]), .wr1_data(wr1_data),
        .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr[3:0])
    );

    function automatic stim_t st(logic rst_n, logic rd, int ra, int rb,
                                 logic w0e, int w0a, logic [63:0] w0d,
                                 logic w1e, int w1a, logic [63:0] w1d,
                                 logic bse, int bsa);
        stim_t s;
        s.rst_n = rst_n; s.rd_en = rd; s.ra = 5'(ra); s.rb = 5'(rb);
        s.w0e = w0e; s.w0a = 5'(w0a); s.w0d = w0d;
        s.w1e = w1e; s.w1a = 5'(w1a); s.w1d = w1d;
        s.bse = bse; s.bsa = 5'(bsa);
        return s;
    endfunction

    function automatic vec_t vc(stim_t s, logic [31:0] e0a, logic e0b,
                                logic [63:0] e1a, logic e1b, logic ev);
        vec_t v;
        v.s = s; v.e0a = e0a; v.e0b = e0b; v.e1a = e1a; v.e1b = e1b; v.ev = ev;
        return v;
    endfunction

    // Architectural view: apply the edge's writes and issue, then read either
    // the post-edge state (bypass) or the state as it stood before the edge.
    task automatic model_step(int c, stim_t s);
        bit          zr  = (c == 0);
        bit          byp = (c == 0);
        int          am  = (c == 0) ? 31 : 15;
        logic [63:0] dm  = (c == 0) ? 64'h0000_0000_FFFF_FFFF : '1;
        logic [63:0] pre [32];
        bit          pb [32];
        int          a;
        if (!s.rst_n) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[c][i] = '0;
                m_busy[c][i] = 0;
            end
            m_ra[c] = '0; m_rb[c] = '0; m_ba[c] = 0; m_bb[c] = 0; m_v[c] = 0;
            return;
        end
        for (int i = 0; i < 32; i++) begin
            pre[i] = m_reg[c][i];
            pb[i]  = m_busy[c][i];
        end
        a = int'(s.w0a) & am;
        if (s.w0e && !(zr && a == 0)) begin m_reg[c][a] = s.w0d & dm; m_busy[c][a] = 0; end
        a = int'(s.w1a) & am;
        if (s.w1e && !(zr && a == 0)) begin m_reg[c][a] = s.w1d & dm; m_busy[c][a] = 0; end
        a = int'(s.bsa) & am;
        if (s.bse && !(zr && a == 0)) m_busy[c][a] = 1;
        m_v[c] = s.rd_en;
        if (s.rd_en) begin
            a = int'(s.ra) & am;
            m_ra[c] = (zr && a == 0) ? 64'd0 : (byp ? m_reg[c][a] : pre[a]);
            m_ba[c] = (zr && a == 0) ? 1'b0 : (byp ? m_busy[c][a] : pb[a]);
            a = int'(s.rb) & am;
            m_rb[c] = (zr && a == 0) ? 64'd0 : (byp ? m_reg[c][a] : pre[a]);
            m_bb[c] = (zr && a == 0) ? 1'b0 : (byp ? m_busy[c][a] : pb[a]);
        end
    endtask

    task automatic cycle(stim_t s);
        reset_n = s.rst_n; rd_en = s.rd_en; rd_addr_a = s.ra; rd_addr_b = s.rb;
        wr0_en = s.w0e; wr0_addr = s.w0a; wr0_data = s.w0d;
        wr1_en = s.w1e; wr1_addr = s.w1a; wr1_data = s.w1d;
        busy_set_en = s.bse; busy_set_addr = s.bsa;
        @(posedge clock);
        model_step(0, s);
        model_step(1, s);
        #1;
    endtask

    task automatic chk(string name, int idx, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step=%0d got=%h expected=%h", name, idx, act, exp);
        end
    endtask

    vec_t tbl [19];

    initial begin
        tbl[0]  = vc(st(0,0, 0, 0, 0, 0,64'h0,               0,0,64'h0,                0,0), 32'h0, 0, 64'h0, 0, 0);
        tbl[1]  = vc(st(1,0, 0, 0, 1, 5,64'hDEADBEEF,        0,0,64'h0,                0,0), 32'h0, 0, 64'h0, 0, 0);
        tbl[2]  = vc(st(0,1, 5, 5, 1, 5,64'h1111,            0,0,64'h0,                1,5), 32'h0, 0, 64'h0, 0, 0);
        tbl[3]  = vc(st(1,1, 5, 5, 0, 0,64'h0,               0,0,64'h0,                0,0), 32'h0, 0, 64'h0, 0, 1);
        tbl[4]  = vc(st(1,0, 0, 0, 1, 7,64'h12345678,        0,0,64'h0,                0,0), 32'h0, 0, 64'h0, 0, 0);
        tbl[5]  = vc(st(1,1, 7, 7, 0, 0,64'h0,               0,0,64'h0,                0,0), 32'h12345678, 0, 64'h12345678, 0, 1);
        tbl[6]  = vc(st(1,1, 9, 9, 1, 9,64'hAAAA0000,        1,9,64'h5555FFFF,         0,0), 32'h5555FFFF, 0, 64'h0, 0, 1);
        tbl[7]  = vc(st(1,1, 9, 9, 0, 0,64'h0,               0,0,64'h0,                0,0), 32'h5555FFFF, 0, 64'h5555FFFF, 0, 1);
        tbl[8]  = vc(st(1,0, 0, 0, 1, 0,64'hFFFFFFFFFFFFFFFF,0,0,64'h0,                1,0), 32'h5555FFFF, 0, 64'h5555FFFF, 0, 0);
        tbl[9]  = vc(st(1,1, 0, 0, 0, 0,64'h0,               0,0,64'h0,                0,0), 32'h0, 0, 64'hFFFFFFFFFFFFFFFF, 1, 1);
        tbl[10] = vc(st(1,1, 3, 3, 0, 0,64'h0,               0,0,64'h0,                1,3), 32'h0, 1, 64'h0, 0, 1);
        tbl[11] = vc(st(1,1, 3, 3, 0, 0,64'h0,               0,0,64'h0,                0,0), 32'h0, 1, 64'h0, 1, 1);
        tbl[12] = vc(st(1,1, 3, 3, 0, 0,64'h0,               1,3,64'h77,               1,3), 32'h77, 1, 64'h0, 1, 1);
        tbl[13] = vc(st(1,1, 3, 3, 0, 0,64'h0,               1,3,64'h88,               0,0), 32'h88, 0, 64'h77, 1, 1);
        tbl[14] = vc(st(1,1, 3, 3, 0, 0,64'h0,               0,0,64'h0,                0,0), 32'h88, 0, 64'h88, 0, 1);
        tbl[15] = vc(st(1,0, 0, 0, 1,15,64'h0123456789ABCDEF,0,0,64'h0,                0,0), 32'h88, 0, 64'h88, 0, 0);
        tbl[16] = vc(st(1,1,15, 0, 0, 0,64'h0,               0,0,64'h0,                0,0), 32'h89ABCDEF, 0, 64'h0123456789ABCDEF, 0, 1);
        tbl[17] = vc(st(1,1, 0, 0, 0, 0,64'h0,               0,0,64'h0,                0,0), 32'h0, 0, 64'hFFFFFFFFFFFFFFFF, 1, 1);
        tbl[18] = vc(st(1,1,16,16, 0, 0,64'h0,               0,0,64'h0,                0,0), 32'h0, 0, 64'hFFFFFFFFFFFFFFFF, 1, 1);

        for (int i = 0; i < 19; i++) begin
            cycle(tbl[i].s);
            chk("dut0_rd_data_a", i, {32'h0, o0_ra}, {32'h0, tbl[i].e0a});
            chk("dut0_rd_busy_a", i, 64'(o0_ba), 64'(tbl[i].e0b));
            chk("dut0_rd_valid",  i, 64'(o0_v),  64'(tbl[i].ev));
            chk("dut1_rd_data_a", i, o1_ra, tbl[i].e1a);
            chk("dut1_rd_busy_a", i, 64'(o1_ba), 64'(tbl[i].e1b));
            chk("dut1_rd_valid",  i, 64'(o1_v),  64'(tbl[i].ev));
        end

        for (int i = 0; i < 600; i++) begin
            stim_t s;
            int    hi;
            hi = ($urandom_range(0, 3) == 0) ? 31 : 5;
            s = st(($urandom_range(0, 49) != 0), 1'($urandom_range(0, 1)),
                   $urandom_range(0, hi), $urandom_range(0, hi),
                   1'($urandom_range(0, 1)), $urandom_range(0, hi), {$urandom, $urandom},
                   1'($urandom_range(0, 1)), $urandom_range(0, hi), {$urandom, $urandom},
                   1'($urandom_range(0, 1)), $urandom_range(0, hi));
            cycle(s);
            chk("rnd0_rd_data_a", i, {32'h0, o0_ra}, m_ra[0]);
            chk("rnd0_rd_data_b", i, {32'h0, o0_rb}, m_rb[0]);
            chk("rnd0_rd_busy_a", i, 64'(o0_ba), 64'(m_ba[0]));
            chk("rnd0_rd_busy_b", i, 64'(o0_bb), 64'(m_bb[0]));
            chk("rnd0_rd_valid",  i, 64'(o0_v),  64'(m_v[0]));
            chk("rnd1_rd_data_a", i, o1_ra, m_ra[1]);
            chk("rnd1_rd_data_b", i, o1_rb, m_rb[1]);
            chk("rnd1_rd_busy_a", i, 64'(o1_ba), 64'(m_ba[1]));
            chk("rnd1_rd_busy_b", i, 64'(o1_bb), 64'(m_bb[1]));
            chk("rnd1_rd_valid",  i, 64'(o1_v),  64'(m_v[1]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
